rom_load_bridge: RTL and testbench

//  Buffers 16-bit cartridge download words from hps_io ioctl and replays them to ddram as

---
 rtl/rom_load_pkg.sv | 42 ++++
 rtl/rom_load_bridge_if.sv | 31 +++
 rtl/rom_load_fifo.sv | 75 +++++++
 rtl/rom_load_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_rom_load_bridge.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_load_pkg.sv
// -----------------------------------------------------------------------------
// rom_load_pkg
// Shared types and constants for the cartridge download bridge:
//   - FSM state encoding (SYNC / IDLE / WAIT_ACK)
//   - FIFO entry layout {addr, data}
//   - byte offsets of the cartridge serial-number field in the ROM header
//   - serial numbers of titles that need the SRAM quirk
//   - byte-swap helper (host {lo,hi} order -> big-endian ROM order)
// -----------------------------------------------------------------------------
package rom_load_pkg;

  localparam int ROM_AW = 25;

  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [15:0]       data;
  } fifo_entry_t;

  // Serial-number field of the Genesis header, one word per offset.
  localparam logic [31:0] HDR_ID0 = 32'h0000_0184;
  localparam logic [31:0] HDR_ID1 = 32'h0000_0186;
  localparam logic [31:0] HDR_ID2 = 32'h0000_0188;
  localparam logic [31:0] HDR_ID3 = 32'h0000_018A;

  // Seven-character IDs need the first byte of the word at HDR_ID3.
  localparam logic [55:0] QUIRK_ID7_A = "-081276";
  localparam logic [55:0] QUIRK_ID7_B = "-081586";
  localparam logic [47:0] QUIRK_ID6_A = "-81406";
  localparam logic [47:0] QUIRK_ID6_B = "-81576";
  localparam logic [47:0] QUIRK_ID6_C = "-81476";

  function automatic logic [15:0] swap_bytes(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/rom_load_bridge_if.sv
// -----------------------------------------------------------------------------
// rom_load_bridge_if
// Toggle-handshake write channel between the download bridge and ddram.
//   mem_addr   : byte write address, held while a request is outstanding
//   mem_din    : write data (big-endian ROM byte order)
//   mem_we_req : toggles once per new write
//   mem_we_ack : ddram toggles it to match mem_we_req when the write completes
// Modports: master = bridge side, slave = ddram side.
// -----------------------------------------------------------------------------
interface rom_load_bridge_if #(
  parameter int AW = 25
);
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_we_req;
  logic          mem_we_ack;

  modport master (
    output mem_addr,
    output mem_din,
    output mem_we_req,
    input  mem_we_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_din,
    input  mem_we_req,
    output mem_we_ack
  );
endinterface

// File: rtl/rom_load_fifo.sv
// -----------------------------------------------------------------------------
// rom_load_fifo
// DEPTH x W synchronous FIFO with occupancy count and synchronous flush.
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   push_i, wdata_i  : write strobe and data (caller guarantees !full or flush)
//   pop_i            : read strobe (caller guarantees !empty and !flush)
//   flush_i          : discard contents; a push in the same cycle is kept
//   rdata_o          : head entry (show-ahead)
//   count_o          : current occupancy
//   count_next_o     : occupancy after this cycle's push/pop/flush
//   full_o, empty_o  : occupancy flags
// -----------------------------------------------------------------------------
module rom_load_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 41
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_next_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_idx;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_idx   = wr_ptr_q;
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    if (flush_i) begin
      // Restart from slot 0 so a word pushed with the flush becomes the head.
      wr_idx   = '0;
      wr_ptr_d = PW'(push_i);
      rd_ptr_d = '0;
      count_d  = CW'(push_i);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_i) mem_q[wr_idx] <= wdata_i;
  end

  assign rdata_o      = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);

endmodule

// File: rtl/rom_load_bridge.sv
// -----------------------------------------------------------------------------
// rom_load_bridge
// Buffers 16-bit cartridge download words from hps_io and replays them to ddram
// as toggle-handshake writes, owning the ioctl_wait backpressure. Also reports
// the loaded ROM size and, optionally, a header-derived SRAM quirk flag.
//
// Ports:
//   clk_sys, reset_n : system clock, asynchronous active-low reset
//   dl_active        : ioctl_download level; rising edge starts a new download
//   dl_wr            : one-cycle strobe, dl_addr/dl_data valid
//   dl_addr, dl_data : byte address and host-order word {lo,hi}
//   dl_wait          : registered backpressure to hps_io
//   mem              : rom_load_bridge_if.master toggle write channel to ddram
//   rom_size         : last accepted dl_addr[AW-1:1] of the current download
//   dl_done          : one-cycle pulse once the download has ended and drained
//   overflow         : sticky, a word arrived with the FIFO full and was dropped
//   sram_quirk       : header serial number matched a known SRAM-quirk title
//
// Build option: define CART_ID_SNIFF_EN to enable header capture and the
// sram_quirk match; otherwise sram_quirk is tied to 0.
// -----------------------------------------------------------------------------
module rom_load_bridge
  import rom_load_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ROM_AW
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [AW-1:0]     dl_addr,
  input  logic [15:0]       dl_data,
  output logic              dl_wait,
  rom_load_bridge_if.master mem,
  output logic [AW-2:0]     rom_size,
  output logic              dl_done,
  output logic              overflow,
  output logic              sram_quirk
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic          act_q;
  logic          rise, fall, flush;
  logic          push_ok, drop;
  logic          issue, realign;
  logic          full, empty;
  logic [CW-1:0] count, count_next;
  fifo_entry_t   wr_entry, head;

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_din_q, mem_din_d;
  logic          req_q, req_d;
  logic          dl_wait_q;
  logic [AW-2:0] rom_size_q;
  logic          overflow_q;
  logic          armed_q;
  logic          dl_done_q;
  logic          fire;

  // A new download discards whatever the previous one left queued.
  assign rise  = dl_active & ~act_q;
  assign fall  = ~dl_active & act_q;
  assign flush = rise;

  // The flush empties the FIFO this cycle, so a coincident word always fits.
  assign push_ok = dl_wr & (flush | ~full);
  assign drop    = dl_wr & full & ~flush;

  always_comb begin
    wr_entry      = '0;
    wr_entry.addr = ROM_AW'(dl_addr);
    wr_entry.data = dl_data;
  end

  rom_load_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .push_i       (push_ok),
    .wdata_i      (wr_entry),
    .pop_i        (issue),
    .flush_i      (flush),
    .rdata_o      (head),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (full),
    .empty_o      (empty)
  );

  // FSM state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= SYNC;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:     state_d = IDLE;
      IDLE:     if (issue) state_d = WAIT_ACK;
      WAIT_ACK: if (mem.mem_we_ack == req_q) state_d = IDLE;
      default:  state_d = SYNC;
    endcase
  end

  // FSM outputs; no issue on a flush cycle, the head belongs to the old download.
  always_comb begin
    issue   = 1'b0;
    realign = 1'b0;
    unique case (state_q)
      SYNC:    realign = 1'b1;
      IDLE:    issue   = ~empty & ~flush;
      default: ;
    endcase
  end

  // Write channel: after reset ddram may hold either ack phase, so SYNC copies it.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    req_d      = req_q;
    if (realign) begin
      req_d = mem.mem_we_ack;
    end else if (issue) begin
      mem_addr_d = AW'(head.addr);
      mem_din_d  = swap_bytes(head.data);
      req_d      = ~req_q;
    end
  end

  // dl_done needs the download over, nothing queued, nothing in flight, and no
  // late word arriving this very cycle.
  assign fire = armed_q & ~dl_active & empty & (state_q == IDLE) & ~push_ok;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      act_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      req_q      <= 1'b0;
      dl_wait_q  <= 1'b0;
      rom_size_q <= '0;
      overflow_q <= 1'b0;
      armed_q    <= 1'b0;
      dl_done_q  <= 1'b0;
    end else begin
      act_q      <= dl_active;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      req_q      <= req_d;
      // Rising at DEPTH-1 leaves one slot for the word hps_io may still send.
      dl_wait_q  <= (count_next >= CW'(DEPTH - 1));
      dl_done_q  <= fire;

      if (push_ok)    rom_size_q <= dl_addr[AW-1:1];
      else if (flush) rom_size_q <= '0;

      if (flush)     overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;

      if (flush)     armed_q <= 1'b0;
      else if (fire) armed_q <= 1'b0;
      else if (fall) armed_q <= 1'b1;
    end
  end

  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_din    = mem_din_q;
  assign mem.mem_we_req = req_q;
  assign dl_wait        = dl_wait_q;
  assign rom_size       = rom_size_q;
  assign overflow       = overflow_q;
  assign dl_done        = dl_done_q;

`ifdef CART_ID_SNIFF_EN
  logic [47:0] cart_id_q;
  logic        quirk_q;
  logic [15:0] sw_data;
  logic        id_match;

  assign sw_data = swap_bytes(dl_data);

  // The seventh ID character is the first byte of the word being pushed now.
  assign id_match = ({cart_id_q, sw_data[15:8]} == QUIRK_ID7_A) ||
                    ({cart_id_q, sw_data[15:8]} == QUIRK_ID7_B) ||
                    (cart_id_q == QUIRK_ID6_A) ||
                    (cart_id_q == QUIRK_ID6_B) ||
                    (cart_id_q == QUIRK_ID6_C);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cart_id_q <= '0;
      quirk_q   <= 1'b0;
    end else begin
      if (flush) quirk_q <= 1'b0;
      if (push_ok) begin
        if (dl_addr == AW'(HDR_ID0)) cart_id_q[47:32] <= sw_data;
        if (dl_addr == AW'(HDR_ID1)) cart_id_q[31:16] <= sw_data;
        if (dl_addr == AW'(HDR_ID2)) cart_id_q[15:0]  <= sw_data;
        if ((dl_addr == AW'(HDR_ID3)) && id_match) quirk_q <= 1'b1;
      end
    end
  end

  assign sram_quirk = quirk_q;
`else
  assign sram_quirk = 1'b0;
`endif

endmodule

// File: tb/tb_rom_load_bridge.sv
// -----------------------------------------------------------------------------
// tb_rom_load_bridge
// Self-checking bench for rom_load_bridge: an hps_io-like driver that honours
// dl_wait with one cycle of latency, a ddram responder with programmable ack
// delay, and an in-order scoreboard of expected writes built from the words
// the driver sends.
// -----------------------------------------------------------------------------
module tb_rom_load_bridge;
  localparam int AW    = 25;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dl_active;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [15:0]   dl_data;
  logic          dl_wait;
  logic [AW-2:0] rom_size;
  logic          dl_done;
  logic          overflow;
  logic          sram_quirk;

  rom_load_bridge_if #(.AW(AW)) mem_bus ();

  rom_load_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys    (clk),
    .reset_n    (reset_n),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_wait    (dl_wait),
    .mem        (mem_bus.master),
    .rom_size   (rom_size),
    .dl_done    (dl_done),
    .overflow   (overflow),
    .sram_quirk (sram_quirk)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bench state ----------------
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // hps_io sees dl_wait one cycle late.
  logic wait_prev = 1'b0;
  always @(posedge clk) wait_prev <= dl_wait;

  logic          mdl_en    = 1'b0;
  logic          hold      = 1'b0;
  logic          rand_dly  = 1'b0;
  int            fixed_dly = 0;

  logic [AW+15:0] exp_mem [0:255];
  int             exp_wr = 0;

  // ddram responder / scoreboard
  logic          ack_r = 1'b1;
  logic          pend  = 1'b0;
  int            cnt   = 0;
  logic [AW-1:0] cap_addr = '0;
  logic [15:0]   cap_din  = '0;
  int            writes_seen = 0;
  int            exp_rd = 0;
  int            ack_cyc = 0;
  logic [AW+15:0] e = '0;

  assign mem_bus.mem_we_ack = ack_r;

  always @(negedge clk) begin
    if (mdl_en) begin
      if (!pend) begin
        if (mem_bus.mem_we_req != ack_r) begin
          pend     = 1'b1;
          cap_addr = mem_bus.mem_addr;
          cap_din  = mem_bus.mem_din;
          writes_seen++;
          cnt = rand_dly ? int'($urandom_range(0, 4)) : fixed_dly;
          if (exp_rd >= exp_wr) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = exp_mem[exp_rd[7:0]];
            exp_rd++;
            chk("wr_addr", cap_addr, e[AW+15:16]);
            chk("wr_data", cap_din, e[15:0]);
          end
        end
      end else if (!hold) begin
        if (cnt == 0) begin
          chk("hold_addr", mem_bus.mem_addr, cap_addr);
          chk("hold_data", mem_bus.mem_din, cap_din);
          ack_r   = ~ack_r;
          pend    = 1'b0;
          ack_cyc = cyc;
        end else begin
          cnt--;
        end
      end
    end
  end

  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (mdl_en && dl_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [15:0] swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  function automatic bit quirk_ref(input string h);
    if (h.len() != 7) return 1'b0;
`ifdef CART_ID_SNIFF_EN
    begin
      string id6;
      id6 = h.substr(0, 5);
      return (h == "-081276") || (h == "-081586") ||
             (id6 == "-81406") || (id6 == "-81576") || (id6 == "-81476");
    end
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic expect_write(input logic [AW-1:0] a, input logic [15:0] d);
    exp_mem[exp_wr[7:0]] = {a, swap16(d)};
    exp_wr++;
  endtask

  task automatic push_raw(input logic [AW-1:0] a, input logic [15:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    @(posedge clk); #1;
    dl_wr = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [15:0] d);
    int g = 0;
    while (wait_prev && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 500) chk("wait_timeout", 0, 1);
    expect_write(a, d);
    push_raw(a, d);
  endtask

  task automatic set_active(input logic v);
    dl_active = v;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g = 0;
    while (!((exp_rd == exp_wr) && !pend) && g < 3000) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 3000) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  int            ws0, db;
  logic [AW-1:0] a;
  logic [15:0]   d;
  string         hdrs [3];

  initial begin
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", mem_bus.mem_we_req, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_din", mem_bus.mem_din, 0);
    chk("rst_wait", dl_wait, 0);
    chk("rst_rom_size", rom_size, 0);
    chk("rst_done", dl_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_quirk", sram_quirk, 0);

    // 1: toggles realigned to ack=1, no spurious write
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_req_sync", mem_bus.mem_we_req, 1);
    mdl_en = 1'b1;
    ws0 = writes_seen;
    repeat (5) @(posedge clk);
    #1;
    chk("t1_no_write", writes_seen - ws0, 0);

    // 2: single word, ack 3 cycles later
    set_active(1'b1);
    fixed_dly = 3;
    ws0 = writes_seen;
    send_word('0, 16'h1234);
    drain();
    chk("t2_writes", writes_seen - ws0, 1);
    chk("t2_din", cap_din, 16'h3412);
    chk("t2_addr", cap_addr, 0);
    chk("t2_rom_size", rom_size, 0);

    // 3: burst of 8 with slow ack; wait must rise at occupancy 3
    fixed_dly = 20;
    ws0 = writes_seen;
    for (int i = 0; i < 8; i++) begin
      send_word(AW'(32'h100 + 2 * i), 16'($urandom));
      if (i == 2) chk("t3_wait_lo", dl_wait, 0);
      if (i == 3) chk("t3_wait_hi", dl_wait, 1);
    end
    drain();
    chk("t3_writes", writes_seen - ws0, 8);
    chk("t3_ovf", overflow, 0);
    chk("t3_rom_size", rom_size, 25'h10E >> 1);

    // 4: push into a full FIFO ignoring wait
    set_active(1'b0);
    set_active(1'b1);
    fixed_dly = 1;
    hold = 1'b1;
    ws0 = writes_seen;
    for (int i = 0; i < 6; i++) begin
      a = AW'(32'h200 + 2 * i);
      d = 16'hA000 + 16'(i);
      if (i < 5) expect_write(a, d);
      push_raw(a, d);
      if (i == 4) chk("t4_ovf_pre", overflow, 0);
    end
    chk("t4_ovf", overflow, 1);
    chk("t4_rom_size", rom_size, 25'h208 >> 1);
    hold = 1'b0;
    drain();
    chk("t4_writes", writes_seen - ws0, 5);
    chk("t4_ovf_sticky", overflow, 1);
    set_active(1'b0);
    set_active(1'b1);
    chk("t4_ovf_clr", overflow, 0);
    chk("t4_rom_size_clr", rom_size, 0);

    // 5: download ends with two words queued
    fixed_dly = 5;
    db = done_cnt;
    send_word(AW'(32'h300), 16'h5A5A);
    send_word(AW'(32'h302), 16'hC3C3);
    set_active(1'b0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("t5_done_once", done_cnt - db, 1);
    chk("t5_done_timing", done_cyc - ack_cyc, 2);

    // 6: header sniffing
    hdrs[0] = "-81406X";
    hdrs[1] = "-081586";
    hdrs[2] = "-081277";
    fixed_dly = 0;
    for (int h = 0; h < 3; h++) begin
      set_active(1'b0);
      set_active(1'b1);
      chk("t6_quirk_clr", sram_quirk, 0);
      for (int k = 0; k < 3; k++)
        send_word(AW'(32'h184 + 2 * k), {hdrs[h][2*k+1], hdrs[h][2*k]});
      send_word(AW'(32'h18A), {8'h20, hdrs[h][6]});
      drain();
      chk("t6_quirk", sram_quirk, quirk_ref(hdrs[h]));
    end
    set_active(1'b0);
    set_active(1'b1);
    chk("t6_quirk_new_dl", sram_quirk, 0);

    // random download with random ack latency and gaps
    set_active(1'b0);
    set_active(1'b1);
    rand_dly = 1'b1;
    ws0 = writes_seen;
    a = AW'($urandom) & ~AW'(1);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_word(a, 16'($urandom));
      if (i != 39) a = a + AW'(2);
    end
    db = done_cnt;
    set_active(1'b0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("rnd_writes", writes_seen - ws0, 40);
    chk("rnd_rom_size", rom_size, a[AW-1:1]);
    chk("rnd_ovf", overflow, 0);
    chk("rnd_done_once", done_cnt - db, 1);
    chk("rnd_done_timing", done_cyc - ack_cyc, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
